decoder_fixed_point_seq: RTL and testbench
==========================================

// Module: decoder_fixed_point_seq
// PURPOSE
//  Latent-to-output dense layer: out[j] = sat(sum_i z[i]*w[j][i] + b[j]); counterpart of the 9->4 encoder.
//  Maps M_input latent words back to N_output words. One shared multiplier is time-multiplexed over all weights.
//  Sits after the encoder / latent stage. Data words are 32-bit two's-complement fixed point, FRAC fraction bits.
// PARAMETERS
//  M_input   4   latent (input) word count
//  N_output  9   output word count
//  BITSIZE   32  data word width
//  FRAC      26  fraction bits (1.0 = 32'h0400_0000)
// PORTS
//  clk        in   1                    single clock, rising edge
//  rst_n      in   1                    reset, asynchronous assert, active low
//  in_valid   in   1                    z valid
//  in_ready   out  1                    decoder can accept z
//  z          in   M_input*BITSIZE      latent words; z[i] = z[i*BITSIZE +: BITSIZE]
//  w          in   N*M*BITSIZE          weights; w[j][i] at ((j*M_input+i)*BITSIZE) +: BITSIZE
//  b          in   N_output*BITSIZE     bias; b[j] at j*BITSIZE +: BITSIZE
//  out_valid  out  1                    out holds a complete result
//  out_ready  in   1                    consumer takes out
//  out        out  N_output*BITSIZE     result; out[j] at j*BITSIZE +: BITSIZE
//  busy       out  1                    high in MAC/STORE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, out=0, acc=0, i=j=0.
//  - Accept: in IDLE, in_ready=1; in_valid&&in_ready registers z into z_reg and enters MAC.
//  - w and b are not registered. Source holds them stable from accept until out_valid.
//  - States and transitions:
//      IDLE  -> MAC   on accept
//      MAC   -> STORE when i==M_input-1
//      STORE -> MAC   when j<N_output-1
//      STORE -> DONE  when j==N_output-1
//      DONE  -> IDLE  on out_valid&&out_ready
//  - MAC: acc += z_reg[i]*w[j][i], one product per cycle; i increments.
//  - STORE: out_reg[j] = sat((acc + (b[j]<<<FRAC)) >>> FRAC); acc cleared; i=0; j increments.
//  - DONE: out_valid=1. in_ready=0 outside IDLE, so in_valid there is ignored.
//  - Latency: accept at edge 0 -> out_valid high after N_output*(M_input+1) edges (45 at defaults).
//  - Throughput: 1 result per N*(M+1)+1 cycles at best.
//  - Arithmetic:
//      product: signed 2*BITSIZE
//      acc: signed 2*BITSIZE+clog2(M_input+1), no internal overflow
//      shift: arithmetic (floor toward -inf), no rounding
//      saturate to [32'h8000_0000, 32'h7FFF_FFFF]
//  - Backpressure: out and out_valid hold unchanged while out_ready=0, any duration.
//  - out_ready high on the first DONE cycle: transfer that cycle, IDLE next cycle.
//  - out_ready while out_valid=0 has no effect.
//  - out updates per word during STORE. Only the word set during out_valid is contractual.
//  - Reset mid-operation: immediate abort, all outputs to reset values, partial results discarded.
// STRUCTURE
//  - fxp_pkg:
//      FRAC, BITSIZE, ACC_W
//      SAT_MAX / SAT_MIN constants
//      state enum {IDLE, MAC, STORE, DONE}
//      shared with encoder-side blocks
//  - Sub-module fxp_mac_sat:
//      signed multiply-accumulate
//      bias align, shift, saturate
//      combinational datapath, acc register kept in top
//  - Top: FSM, i/j counters, z_reg, out_reg bank, handshake.
// TESTING
//  1. Unity: z=all 32'h0400_0000, w=all 32'h0400_0000, b=0 -> every out=32'h1000_0000 (4.0); out_valid after 45 edges.
//  2. Bias only: w=0, b[j]=j*32'h0400_0000 -> out[j]=b[j]; out[8]=32'h2000_0000.
//  3. Saturation:
//     z=all 32'h4000_0000 (16.0), w=all 32'h4000_0000 -> all out=32'h7FFF_FFFF.
//     Same with w=32'hC000_0000 -> all out=32'h8000_0000.
//  4. Floor truncation: z[0]=32'h0200_0000 (0.5), others 0, b=0.
//     w[j][0]=32'h0000_0001 -> out=0.
//     w[j][0]=32'hFFFF_FFFF -> out=32'hFFFF_FFFF.
//  5. Backpressure: out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0.
//     in_valid pulses are ignored. Raise out_ready -> one transfer, in_ready=1 next cycle.
//  6. Reset mid-MAC: rst_n=0 at edge 20 -> immediately out_valid=0, out=0, in_ready=1.
//     New transaction (test 1 data) after release gives correct result in 45 edges.

Source files
------------

// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point definitions for the encoder/decoder dense layers.
//   BITSIZE / FRAC    : default data word width and fraction bits (1.0 = 1 << FRAC)
//   ACC_W             : accumulator width for the default 4-term dot product
//   SAT_MAX / SAT_MIN : saturation limits of a BITSIZE-bit output word
//   state_t           : sequencer states shared by the layer controllers
package fxp_pkg;

    localparam int BITSIZE   = 32;
    localparam int FRAC      = 26;
    localparam int M_DEFAULT = 4;
    localparam int ACC_W     = 2*BITSIZE + $clog2(M_DEFAULT + 1);

    localparam logic [BITSIZE-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [BITSIZE-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Accumulator width that holds the sum of m full-scale products without overflow.
    function automatic int acc_width(input int m_words, input int bits);
        return 2*bits + $clog2(m_words + 1);
    endfunction

endpackage

// File: rtl/fxp_mac_sat.sv
// fxp_mac_sat: combinational fixed-point datapath shared by the dense layers.
//   acc      in  ACC_W    current accumulator value (register lives in the caller)
//   z_word   in  BITSIZE  input word for this product
//   w_word   in  BITSIZE  weight for this product
//   b_word   in  BITSIZE  bias of the output word being finished
//   acc_next out ACC_W    acc + z_word*w_word
//   result   out BITSIZE  sat((acc + (b_word <<< FRAC)) >>> FRAC)
module fxp_mac_sat #(
    parameter int BITSIZE = 32,
    parameter int FRAC    = 26,
    parameter int ACC_W   = 67
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic signed [BITSIZE-1:0] z_word,
    input  logic signed [BITSIZE-1:0] w_word,
    input  logic signed [BITSIZE-1:0] b_word,
    output logic signed [ACC_W-1:0]   acc_next,
    output logic        [BITSIZE-1:0] result
);

    // Clamp a wide accumulator-domain value into one output word.
    function automatic logic [BITSIZE-1:0] sat_word(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
        lo = {{(ACC_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
        if (v > hi)
            return hi[BITSIZE-1:0];
        else if (v < lo)
            return lo[BITSIZE-1:0];
        else
            return v[BITSIZE-1:0];
    endfunction

    // Add the bias (aligned to the product's 2*FRAC scale) and drop FRAC bits.
    // The arithmetic shift floors toward -inf; no rounding is applied.
    function automatic logic signed [ACC_W-1:0] align_shift(
        input logic signed [ACC_W-1:0]   v,
        input logic signed [BITSIZE-1:0] bias
    );
        logic signed [ACC_W-1:0] bias_ext;
        logic signed [ACC_W-1:0] sum;
        bias_ext = {{(ACC_W-BITSIZE){bias[BITSIZE-1]}}, bias};
        sum      = v + (bias_ext <<< FRAC);
        return sum >>> FRAC;
    endfunction

    logic signed [2*BITSIZE-1:0] z_ext;
    logic signed [2*BITSIZE-1:0] w_ext;
    logic signed [2*BITSIZE-1:0] prod;
    logic signed [ACC_W-1:0]     prod_ext;

    // Operands are sign-extended to the product width so the low half of the
    // wide multiply is the exact signed product.
    assign z_ext    = {{BITSIZE{z_word[BITSIZE-1]}}, z_word};
    assign w_ext    = {{BITSIZE{w_word[BITSIZE-1]}}, w_word};
    assign prod     = z_ext * w_ext;
    assign prod_ext = {{(ACC_W-2*BITSIZE){prod[2*BITSIZE-1]}}, prod};

    assign acc_next = acc + prod_ext;
    assign result   = sat_word(align_shift(acc, b_word));

endmodule

// File: rtl/decoder_fixed_point_seq.sv
// decoder_fixed_point_seq: sequential latent-to-output dense layer,
//   out[j] = sat(sum_i z[i]*w[j][i] + b[j]), one shared multiplier, one product per cycle.
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   z handshake; z is captured on accept
//   z                     M_input latent words, z[i] at i*BITSIZE
//   w                     weights, w[j][i] at (j*M_input+i)*BITSIZE; held stable by the source
//   b                     biases, b[j] at j*BITSIZE; held stable by the source
//   out_valid / out_ready result handshake; out holds while out_ready is low
//   out                   N_output result words, out[j] at j*BITSIZE
//   busy                  high while accumulating or storing
module decoder_fixed_point_seq #(
    parameter int M_input  = 4,
    parameter int N_output = 9,
    parameter int BITSIZE  = 32,
    parameter int FRAC     = 26
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [M_input*BITSIZE-1:0]          z,
    input  logic [N_output*M_input*BITSIZE-1:0] w,
    input  logic [N_output*BITSIZE-1:0]         b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_output*BITSIZE-1:0]         out,
    output logic                             busy
);

    import fxp_pkg::*;

    localparam int AW = acc_width(M_input, BITSIZE);
    localparam int IW = (M_input  > 1) ? $clog2(M_input)  : 1;
    localparam int JW = (N_output > 1) ? $clog2(N_output) : 1;

    state_t                    state;
    logic [IW-1:0]             i_cnt;
    logic [JW-1:0]             j_cnt;
    logic signed [AW-1:0]      acc;
    logic signed [AW-1:0]      acc_next;
    logic [BITSIZE-1:0]        store_word;
    logic signed [BITSIZE-1:0] z_reg [M_input];
    logic signed [BITSIZE-1:0] w_arr [N_output][M_input];
    logic signed [BITSIZE-1:0] b_arr [N_output];
    logic [BITSIZE-1:0]        out_reg [N_output];
    logic                      accept;

    for (genvar gj = 0; gj < N_output; gj++) begin : g_unpack
        assign b_arr[gj] = b[gj*BITSIZE +: BITSIZE];
        assign out[gj*BITSIZE +: BITSIZE] = out_reg[gj];
        for (genvar gi = 0; gi < M_input; gi++) begin : g_w
            assign w_arr[gj][gi] = w[(gj*M_input+gi)*BITSIZE +: BITSIZE];
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MAC) || (state == STORE);
    assign accept    = in_valid && in_ready;

    fxp_mac_sat #(
        .BITSIZE (BITSIZE),
        .FRAC    (FRAC),
        .ACC_W   (AW)
    ) u_mac_sat (
        .acc      (acc),
        .z_word   (z_reg[i_cnt]),
        .w_word   (w_arr[j_cnt][i_cnt]),
        .b_word   (b_arr[j_cnt]),
        .acc_next (acc_next),
        .result   (store_word)
    );

    // Latent words are pure data: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < M_input; k++)
                z_reg[k] <= z[k*BITSIZE +: BITSIZE];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i_cnt <= '0;
            j_cnt <= '0;
            acc   <= '0;
            for (int k = 0; k < N_output; k++)
                out_reg[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= MAC;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (i_cnt == IW'(M_input-1))
                        state <= STORE;
                    else
                        i_cnt <= i_cnt + 1'b1;
                end
                STORE: begin
                    // Each output word becomes visible as soon as it is finished;
                    // only the full bank seen under out_valid is meaningful.
                    out_reg[j_cnt] <= store_word;
                    acc            <= '0;
                    i_cnt          <= '0;
                    if (j_cnt == JW'(N_output-1)) begin
                        state <= DONE;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                        state <= MAC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        j_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_fixed_point_seq.sv
module tb_decoder_fixed_point_seq;

    localparam int M  = 4;
    localparam int N  = 9;
    localparam int BW = 32;
    localparam int LAT = N*(M+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [M*BW-1:0]   z;
    logic [N*M*BW-1:0] w;
    logic [N*BW-1:0]   b;
    logic [N*BW-1:0]   out;

    logic signed [31:0] zv [M];
    logic signed [31:0] wv [N][M];
    logic signed [31:0] bv [N];

    int tests  = 0;
    int failed = 0;

    always_comb begin
        z = '0;
        w = '0;
        b = '0;
        for (int i = 0; i < M; i++) z[i*BW +: BW] = zv[i];
        for (int j = 0; j < N; j++) begin
            b[j*BW +: BW] = bv[j];
            for (int i = 0; i < M; i++) w[(j*M+i)*BW +: BW] = wv[j][i];
        end
    end

    decoder_fixed_point_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .w         (w),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact real-valued dot product on wide integers, plus bias,
    // divided by 2^26 with floor, then clamped to the 32-bit range.
    function automatic logic [31:0] ref_word(input int j);
        logic signed [127:0] acc, q, scale, zt, wt, bt;
        scale = 128'sd67108864;
        acc   = '0;
        for (int i = 0; i < M; i++) begin
            zt  = zv[i];
            wt  = wv[j][i];
            acc = acc + zt * wt;
        end
        bt  = bv[j];
        acc = acc + bt * scale;
        q   = acc / scale;
        if (acc < 0 && q * scale != acc) q = q - 1;
        if (q > 128'sd2147483647)  return 32'h7FFF_FFFF;
        if (q < -128'sd2147483648) return 32'h8000_0000;
        return q[31:0];
    endfunction

    task automatic fill(input logic [31:0] zval, input logic [31:0] wval, input logic [31:0] bval);
        for (int i = 0; i < M; i++) zv[i] = zval;
        for (int j = 0; j < N; j++) begin
            bv[j] = bval;
            for (int i = 0; i < M; i++) wv[j][i] = wval;
        end
    endtask

    task automatic start_txn();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    endtask

    task automatic check_const(input string tag, input logic [31:0] exp);
        for (int j = 0; j < N; j++)
            check($sformatf("%s_out%0d", tag, j), 64'(out[j*BW +: BW]), 64'(exp));
    endtask

    task automatic check_model(input string tag);
        for (int j = 0; j < N; j++)
            check($sformatf("%s_out%0d", tag, j), 64'(out[j*BW +: BW]), 64'(ref_word(j)));
    endtask

    task automatic take_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [N*BW-1:0] snap;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fill(32'h0, 32'h0, 32'h0);

        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out", 64'(out == '0), 64'd1);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unity: 4 * (1.0 * 1.0) = 4.0
        fill(32'h0400_0000, 32'h0400_0000, 32'h0);
        start_txn();
        check("unity_busy", 64'(busy), 64'd1);
        check("unity_in_ready_busy", 64'(in_ready), 64'd0);
        wait_done("unity");
        check_const("unity", 32'h1000_0000);
        take_out("unity");

        // Bias only
        fill(32'h0400_0000, 32'h0, 32'h0);
        for (int j = 0; j < N; j++) bv[j] = 32'(j) * 32'h0400_0000;
        start_txn();
        wait_done("bias");
        for (int j = 0; j < N; j++)
            check($sformatf("bias_out%0d", j), 64'(out[j*BW +: BW]), 64'(32'(j) * 32'h0400_0000));
        check("bias_out8_const", 64'(out[8*BW +: BW]), 64'(32'h2000_0000));
        take_out("bias");

        // Saturation both directions
        fill(32'h4000_0000, 32'h4000_0000, 32'h0);
        start_txn();
        wait_done("satpos");
        check_const("satpos", 32'h7FFF_FFFF);
        take_out("satpos");

        fill(32'h4000_0000, 32'hC000_0000, 32'h0);
        start_txn();
        wait_done("satneg");
        check_const("satneg", 32'h8000_0000);
        take_out("satneg");

        // Floor truncation
        fill(32'h0, 32'h0, 32'h0);
        zv[0] = 32'h0200_0000;
        for (int j = 0; j < N; j++) wv[j][0] = 32'h0000_0001;
        start_txn();
        wait_done("floorpos");
        check_const("floorpos", 32'h0);
        take_out("floorpos");

        for (int j = 0; j < N; j++) wv[j][0] = 32'hFFFF_FFFF;
        start_txn();
        wait_done("floorneg");
        check_const("floorneg", 32'hFFFF_FFFF);
        take_out("floorneg");

        // Backpressure with ignored in_valid pulses
        fill(32'h0400_0000, 32'h0400_0000, 32'h0);
        start_txn();
        wait_done("bp");
        snap = out;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k % 2 == 0);
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_out_%0d", k), 64'(out == snap), 64'd1);
            check($sformatf("bp_hold_valid_%0d", k), 64'(out_valid), 64'd1);
            check($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check_const("bp", 32'h1000_0000);
        take_out("bp");
        check("bp_no_restart", 64'(busy), 64'd0);

        // Reset in the middle of accumulation
        fill(32'h0400_0000, 32'h0400_0000, 32'h0);
        start_txn();
        repeat (20) @(posedge clk);
        #1;
        check("midrst_partial_out", 64'(out != '0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out", 64'(out == '0), 64'd1);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_txn();
        wait_done("after_rst");
        check_const("after_rst", 32'h1000_0000);
        take_out("after_rst");

        // Randomized transactions against the reference model
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < M; i++) zv[i] = $signed($urandom) >>> $urandom_range(0, 6);
            for (int j = 0; j < N; j++) begin
                bv[j] = $signed($urandom) >>> $urandom_range(0, 8);
                for (int i = 0; i < M; i++) wv[j][i] = $signed($urandom) >>> $urandom_range(0, 8);
            end
            start_txn();
            wait_done($sformatf("rand%0d", t));
            check_model($sformatf("rand%0d", t));
            // Hold for a random while before taking the result
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            check_model($sformatf("rand%0d_held", t));
            take_out($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
